// File: rtl/step_command_gen_pkg.sv
// Shared definitions for the step command generator.
// Holds the 2-bit FSM state encodings, the default timing parameters and
// small width helpers used by the top level and the button debouncer.
package step_command_gen_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        HOLD_WAIT = 2'd1,
        REPEAT    = 2'd2,
        LOCKOUT   = 2'd3
    } state_t;

    localparam int DEF_DEBOUNCE_CYCLES = 500000;
    localparam int DEF_HOLD_CYCLES     = 25000000;
    localparam int DEF_REPEAT_CYCLES   = 10000000;
    localparam bit DEF_REPEAT_EN       = 1'b1;

    // Bits needed to hold values 0..max_value.
    function automatic int count_width(input int max_value);
        return (max_value < 1) ? 1 : $clog2(max_value + 1);
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/step_command_gen_debouncer.sv
// button_debouncer: 2-flop synchronizer followed by a run-length debouncer.
// Ports:
//   clk   - system clock
//   rst   - asynchronous active-low reset
//   raw   - raw, asynchronous, bouncing button input
//   level - debounced button level
// The run counter counts consecutive synchronized samples that disagree with
// the current level; it accepts the new level once the run has reached
// DEBOUNCE_CYCLES and the input still disagrees. Any agreeing sample clears it.
module button_debouncer
    import step_command_gen_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level
);

    localparam int             CW      = count_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  RUN_MAX = CW'(DEBOUNCE_CYCLES);

    logic [1:0]    sync;
    logic [CW-1:0] run;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync  <= 2'b00;
            level <= 1'b0;
            run   <= '0;
        end else begin
            sync <= {sync[0], raw};
            if (sync[1] == level) begin
                run <= '0;
            end else if (run == RUN_MAX) begin
                // Counter stops at RUN_MAX and is cleared here, so it never wraps.
                level <= sync[1];
                run   <= '0;
            end else begin
                run <= run + 1'b1;
            end
        end
    end

endmodule

// File: rtl/step_command_gen.sv
// step_command_gen: turns two raw push buttons into single-cycle step pulses
// for a BCD up/down counter, with optional hold-to-repeat.
// Ports:
//   clk      - sole clock, rising edge
//   rst      - asynchronous active-low reset
//   btn_up   - raw "count up" button, active-high
//   btn_down - raw "count down" button, active-high
//   enable   - registered one-cycle step pulse
//   up_down  - registered step direction (1 = up), updated only with a pulse
//
// state     | meaning
// IDLE      | waiting for exactly one debounced button
// HOLD_WAIT | first pulse issued, timing the hold delay
// REPEAT    | auto-repeating while the same button is held
// LOCKOUT   | both buttons seen, silent until both are released
module step_command_gen
    import step_command_gen_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
    parameter bit REPEAT_EN       = DEF_REPEAT_EN
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_up,
    input  logic btn_down,
    output logic enable,
    output logic up_down
);

    localparam int            TW          = count_width(max2(HOLD_CYCLES, REPEAT_CYCLES));
    localparam logic [TW-1:0] HOLD_LOAD   = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] REPEAT_LOAD = TW'(REPEAT_CYCLES - 1);

    logic          db_up;
    logic          db_down;
    state_t        state;
    state_t        state_nxt;
    logic          pulse;
    logic          pulse_dir;
    logic          tmr_load;
    logic [TW-1:0] tmr_load_val;
    logic [TW-1:0] timer;
    logic          timer_done;
    logic          active;
    logic          opposite;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_up),
        .level (db_up)
    );

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_down),
        .level (db_down)
    );

    // While holding, up_down always names the button that started the sequence.
    assign active   = up_down ? db_up   : db_down;
    assign opposite = up_down ? db_down : db_up;
    // Waiting on enable keeps pulses apart even when a period is one cycle.
    assign timer_done = (timer == '0) && !enable;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (db_up && db_down)      state_nxt = LOCKOUT;
                else if (db_up || db_down) state_nxt = HOLD_WAIT;
            end
            HOLD_WAIT: begin
                if (opposite)                         state_nxt = LOCKOUT;
                else if (!active)                     state_nxt = IDLE;
                else if (REPEAT_EN && timer_done)     state_nxt = REPEAT;
            end
            REPEAT: begin
                if (opposite)     state_nxt = LOCKOUT;
                else if (!active) state_nxt = IDLE;
            end
            LOCKOUT: begin
                if (!db_up && !db_down) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        pulse        = 1'b0;
        pulse_dir    = up_down;
        tmr_load     = 1'b0;
        tmr_load_val = REPEAT_LOAD;
        case (state)
            IDLE: begin
                if (db_up ^ db_down) begin
                    pulse        = 1'b1;
                    pulse_dir    = db_up;
                    tmr_load     = 1'b1;
                    tmr_load_val = HOLD_LOAD;
                end
            end
            HOLD_WAIT: begin
                if (!opposite && active && REPEAT_EN && timer_done) begin
                    pulse    = 1'b1;
                    tmr_load = 1'b1;
                end
            end
            REPEAT: begin
                if (!opposite && active && timer_done) begin
                    pulse    = 1'b1;
                    tmr_load = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Hold and repeat intervals share this down-counter; it idles at zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer   <= '0;
            enable  <= 1'b0;
            up_down <= 1'b1;
        end else begin
            enable <= pulse;
            if (pulse) begin
                up_down <= pulse_dir;
            end
            if (tmr_load) begin
                timer <= tmr_load_val;
            end else if (timer != '0) begin
                timer <= timer - 1'b1;
            end
        end
    end

endmodule

// File: doc/step_command_gen.md
STEP_COMMAND_GEN -- requirements
Module: step_command_gen

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, meaning consecutive stable cycles required to accept a button level change (legal range 1..2^20-1).
REQ-002 Parameter HOLD_CYCLES, default 25000000, meaning cycles from first step pulse to first auto-repeat pulse (legal range >=1).
REQ-003 Parameter REPEAT_CYCLES, default 10000000, meaning cycles between successive auto-repeat pulses (legal range >=1).
REQ-004 Parameter REPEAT_EN, default 1, meaning 1 enables auto-repeat and 0 limits output to one pulse per press.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 btn_up  input  1  raw, asynchronous, bouncing "count up" button, active-high.
REQ-008 btn_down  input  1  raw, asynchronous, bouncing "count down" button, active-high.
REQ-009 enable  output  1  one-cycle step pulse that drives the downstream BCD counter's enable.
REQ-010 up_down  output  1  step direction (1 = up, 0 = down), valid whenever enable=1 and held between pulses.

Function
REQ-011 Each button SHALL pass through a 2-flop synchronizer before any other logic.
REQ-012 Each synchronized button SHALL feed a debouncer whose output changes only after the synchronized input differs from the current debounced level for DEBOUNCE_CYCLES consecutive cycles; any agreeing sample SHALL clear the debouncer's run counter.
REQ-013 The debouncer run counter SHALL be sized ceil(log2(DEBOUNCE_CYCLES+1)) bits and SHALL never wrap.
REQ-014 The FSM SHALL have exactly these states: IDLE, HOLD_WAIT, REPEAT, LOCKOUT.
REQ-015 IDLE: when exactly one debounced button is high, the FSM SHALL assert enable for one cycle, load up_down (1 for btn_up, 0 for btn_down), and move to HOLD_WAIT.
REQ-016 IDLE: when both debounced buttons are high together, the FSM SHALL emit no pulse and move to LOCKOUT.
REQ-017 Latency: the first enable pulse SHALL occur exactly DEBOUNCE_CYCLES+3 rising edges after the first edge that samples the raw button high, provided the raw level stays stable throughout.
REQ-018 HOLD_WAIT: the FSM SHALL count HOLD_CYCLES from the first pulse; on expiry with the same button still held and REPEAT_EN=1, it SHALL pulse enable and enter REPEAT.
REQ-019 REPEAT: the FSM SHALL pulse enable every REPEAT_CYCLES cycles while the same button remains held.
REQ-020 In HOLD_WAIT or REPEAT, release of the active button SHALL return the FSM to IDLE with no pulse.
REQ-021 In HOLD_WAIT or REPEAT, assertion of the opposite button SHALL move the FSM to LOCKOUT with no pulse.
REQ-022 With REPEAT_EN=0, HOLD_WAIT SHALL emit no further pulses and SHALL exit only on release.
REQ-023 LOCKOUT: the FSM SHALL emit no pulses and SHALL return to IDLE only when both debounced buttons are low.
REQ-024 enable SHALL never be high on two consecutive cycles.
REQ-025 up_down SHALL change only in the cycle a pulse is issued.
REQ-026 enable and up_down SHALL be registered outputs.

Reset
REQ-027 When rst=0, the block SHALL asynchronously clear synchronizers, debounced levels and all counters, set the FSM to IDLE, and drive enable=0 and up_down=1.
REQ-028 A button held through reset release SHALL be debounced afresh, yielding exactly one pulse after DEBOUNCE_CYCLES+3 cycles.
REQ-029 Reset asserted mid-HOLD_WAIT or mid-REPEAT SHALL abort the sequence with no pulse during or on exit from reset.

Structure
REQ-030 A shared header SHALL hold the FSM state encodings (2 bits) and the default parameter values.
REQ-031 A sub-module named button_debouncer (synchronizer plus debounce counter, parameter DEBOUNCE_CYCLES) SHALL be instantiated twice.
REQ-032 The hold and repeat timing SHALL share one counter in the top level.

Verification (DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=3)
REQ-033 btn_up rises at edge 0 and stays stable -> a single enable pulse at edge 7 with up_down=1; no further pulse until edge 17.
REQ-034 btn_down held 40 cycles -> pulses at t0, t0+10, t0+13, t0+16, ... with up_down=0, none after debounced release.
REQ-035 btn_up glitch high for 3 cycles, then low -> enable stays 0 and up_down stays 1.
REQ-036 btn_up held, btn_down pressed at t0+5 -> no pulse from t0+5 onward until both buttons are released and a new press is debounced.
REQ-037 rst driven low at t0+12 during REPEAT with btn_up held, released 5 cycles later -> enable=0 and up_down=1 during reset, then exactly one pulse 7 cycles after release.
REQ-038 REPEAT_EN=0, btn_up held 50 cycles -> exactly one pulse.
